// File: rtl/wb_sram_subsystem.sv
// wb_sram_subsystem: Wishbone slave moving 32-bit words through a byte-wide SRAM, little-endian.
// Each access becomes four back-to-back byte cycles at A..A+3 (modulo depth), then one ACK.
module wb_sram_subsystem #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       ADR_O,
    input  logic [DATA_W-1:0] DAT_O,
    input  logic              WE_O,
    input  logic              STB_O,
    input  logic              CYC_O,
    output logic [DATA_W-1:0] DAT_I,
    output logic              ACK_I,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_cen,
    output logic              sram_wen,
    output logic              sram_oen
);
    typedef enum logic [1:0] {S_IDLE, S_XFER, S_ACK, S_WAIT} state_t;
    state_t            state;
    logic [1:0]        idx;
    logic              we;
    logic              drop;
    logic [DATA_W-1:0] wdata;
    logic [7:0]        rd_byte;
    logic              req;
    logic              unused_adr;
    logic [7:0]        mem [0:2**ADDR_W-1] = '{default: 8'h00};
    wire  [7:0]        sram_dq;
    assign req        = CYC_O & STB_O;
    assign unused_adr = ^ADR_O[31:ADDR_W];
    assign sram_dq    = (!sram_cen && !sram_wen) ? wdata[{idx, 3'b000} +: 8] : 8'hzz;
    assign rd_byte    = (!sram_cen && !sram_oen) ? mem[sram_addr] : 8'h00;
    always_ff @(posedge clk)
        if (!sram_cen && !sram_wen) mem[sram_addr] <= sram_dq;
    // A strobe dropped at any byte edge suppresses the ACK but lets the bytes finish.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            we        <= 1'b0;
            drop      <= 1'b0;
            wdata     <= '0;
            DAT_I     <= '0;
            ACK_I     <= 1'b0;
            sram_addr <= '0;
            sram_cen  <= 1'b1;
            sram_wen  <= 1'b1;
            sram_oen  <= 1'b1;
        end else begin
            case (state)
                S_IDLE: if (req) begin
                    state     <= S_XFER;
                    idx       <= '0;
                    we        <= WE_O;
                    drop      <= 1'b0;
                    wdata     <= DAT_O;
                    sram_addr <= ADR_O[ADDR_W-1:0];
                    sram_cen  <= 1'b0;
                    sram_wen  <= !WE_O;
                    sram_oen  <= WE_O;
                end
                S_XFER: begin
                    if (!we) DAT_I[{idx, 3'b000} +: 8] <= rd_byte;
                    drop      <= drop | !req;
                    idx       <= idx + 2'd1;
                    sram_addr <= sram_addr + 1'b1;
                    if (idx == 2'd3) begin
                        state    <= (drop || !req) ? S_IDLE : S_ACK;
                        ACK_I    <= !(drop || !req);
                        sram_cen <= 1'b1;
                        sram_wen <= 1'b1;
                        sram_oen <= 1'b1;
                    end
                end
                S_ACK: begin
                    ACK_I <= 1'b0;
                    state <= STB_O ? S_WAIT : S_IDLE;
                end
                S_WAIT: if (!STB_O) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
endmodule

// File: tb/tb_wb_sram_subsystem.sv
// tb_wb_sram_subsystem: directed plus random Wishbone word transfers checked every cycle
// against a byte-array model of the subsystem timeline.
module tb_wb_sram_subsystem;
    localparam int AW = 17;
    localparam int N  = 1 << AW;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   adr = '0;
    logic [31:0]   dat = '0;
    logic          we = 1'b0;
    logic          stb = 1'b0;
    logic          cyc = 1'b0;
    logic [31:0]   dat_i;
    logic          ack_i;
    logic [AW-1:0] sram_addr;
    logic          cen, wen, oen;
    int            checks = 0;
    int            errors = 0;
    int            acks = 0;

    wb_sram_subsystem #(.ADDR_W(AW), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .ADR_O(adr), .DAT_O(dat), .WE_O(we), .STB_O(stb), .CYC_O(cyc),
        .DAT_I(dat_i), .ACK_I(ack_i), .sram_addr(sram_addr),
        .sram_cen(cen), .sram_wen(wen), .sram_oen(oen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: ph = -1 idle, 0..3 byte in flight, 4 acking, 5 waiting for strobe release.
    logic [7:0]    m_mem [0:N-1] = '{default: 8'h00};
    int            ph = -1;
    logic [AW-1:0] m_base = '0;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_w = '0;
    logic [31:0]   e_dat = '0;
    logic          m_we = 1'b0;
    logic          m_drop = 1'b0;
    assign m_addr = m_base + AW'(ph);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ph    <= -1;
            e_dat <= '0;
        end else if (ph < 0) begin
            if (cyc && stb) begin
                ph     <= 0;
                m_base <= adr[AW-1:0];
                m_w    <= dat;
                m_we   <= we;
                m_drop <= 1'b0;
            end
        end else if (ph < 4) begin
            if (m_we) m_mem[m_addr] <= m_w[8*ph +: 8];
            else e_dat[8*ph +: 8] <= m_mem[m_addr];
            m_drop <= m_drop || !(cyc && stb);
            ph <= (ph < 3) ? ph + 1 : (m_drop || !(cyc && stb)) ? -1 : 4;
        end else if (ph == 4) ph <= stb ? 5 : -1;
        else if (!stb) ph <= -1;
    end

    always @(negedge clk) if (rst) begin
        chk("ack", ack_i, ph == 4);
        chk("cen", cen, !(ph >= 0 && ph < 4));
        chk("wen", wen, !(ph >= 0 && ph < 4 && m_we));
        chk("oen", oen, !(ph >= 0 && ph < 4 && !m_we));
        chk("dat_i", dat_i, e_dat);
        if (ph >= 0 && ph < 4) chk("sram_addr", sram_addr, m_addr);
        if (ack_i) acks++;
    end

    task automatic go(input logic [31:0] a, input logic [31:0] d, input logic w, input int hold);
        int n0;
        int k;
        n0 = acks;
        adr = a; dat = d; we = w; cyc = 1'b1; stb = 1'b1;
        k = 0;
        do begin @(posedge clk); #2; k++; end while (!ack_i && k < 12);
        chk("latency", k, 5);
        repeat (hold) begin @(posedge clk); #2; end
        stb = 1'b0; cyc = 1'b0;
        @(posedge clk); #2;
        chk("ack_count", acks - n0, 1);
    endtask

    task automatic go_drop(input logic [31:0] a, input logic [31:0] d, input logic w, input int k);
        int n0;
        n0 = acks;
        adr = a; dat = d; we = w; cyc = 1'b1; stb = 1'b1;
        repeat (k) begin @(posedge clk); #2; end
        stb = 1'b0; cyc = 1'b0;
        repeat (6) begin @(posedge clk); #2; end
        chk("drop_no_ack", acks - n0, 0);
    endtask

    task automatic mem4(input logic [AW-1:0] a, input logic [31:0] exp);
        for (int i = 0; i < 4; i++) chk("mem", dut.mem[a + AW'(i)], exp[8*i +: 8]);
    endtask

    initial begin
        #3 rst = 1'b0;
        #1;
        chk("rst_ack", ack_i, 0);
        chk("rst_dat", dat_i, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_strobes", {cen, wen, oen}, 3'b111);
        @(posedge clk); #2 rst = 1'b1;
        go(32'hABCDABCD, 32'hABCDEF12, 1'b1, 1);
        mem4(17'h1ABCD, 32'hABCDEF12);
        go(32'h00000752, 32'h12345678, 1'b1, 0);
        mem4(17'h00752, 32'h12345678);
        mem4(17'h1ABCD, 32'hABCDEF12);
        chk("model_pin", m_mem[17'h00752], 8'h78);
        go(32'hABCDABCD, 32'h0, 1'b0, 0);
        chk("rd_1abcd", dat_i, 32'hABCDEF12);
        go(32'h00000752, 32'h0, 1'b0, 2);
        chk("rd_752", dat_i, 32'h12345678);
        adr = 32'hABCDFFF0; dat = 32'h01020304; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        repeat (3) begin @(posedge clk); #2; end
        rst = 1'b0;
        #1;
        chk("mid_rst_ack", ack_i, 0);
        chk("mid_rst_dat", dat_i, 0);
        chk("mid_rst_addr", sram_addr, 0);
        chk("mid_rst_strobes", {cen, wen, oen}, 3'b111);
        mem4(17'h1FFF0, 32'h00000304);
        @(posedge clk); #2;
        rst = 1'b1; dat = 32'hABCD2024;
        go(32'hABCDFFF0, 32'hABCD2024, 1'b1, 0);
        mem4(17'h1FFF0, 32'hABCD2024);
        go(32'h0001FFFE, 32'h11223344, 1'b1, 3);
        chk("wrap_fffe", dut.mem[17'h1FFFE], 8'h44);
        chk("wrap_ffff", dut.mem[17'h1FFFF], 8'h33);
        chk("wrap_0", dut.mem[17'h00000], 8'h22);
        chk("wrap_1", dut.mem[17'h00001], 8'h11);
        go(32'h0001FFFE, 32'h0, 1'b0, 0);
        chk("rd_wrap", dat_i, 32'h11223344);
        for (int t = 0; t < 60; t++) begin
            logic [31:0] a;
            int r;
            r = $urandom_range(0, 2);
            a = (r == 0) ? 32'h1FFF8 + $urandom_range(0, 15) :
                (r == 1) ? 32'h00100 + $urandom_range(0, 15) : $urandom;
            a = {$urandom_range(0, 32767), a[AW-1:0]};
            if ($urandom_range(0, 5) == 0)
                go_drop(a, $urandom, 1'($urandom_range(0, 1)), $urandom_range(1, 4));
            else
                go(a, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end
        for (int i = 0; i < 24; i++) begin
            chk("sweep_lo", dut.mem[AW'(i)], m_mem[AW'(i)]);
            chk("sweep_mid", dut.mem[AW'(32'h100 + i)], m_mem[AW'(32'h100 + i)]);
            chk("sweep_hi", dut.mem[AW'(32'h1FFF0 + i)], m_mem[AW'(32'h1FFF0 + i)]);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
